// File: rtl/la_counter_ctrl.sv
// Count-register sequencer for the user project: arbitrates LA load, Wishbone LOAD writes and
// prescaled increments, and publishes a status beacon plus a terminal-count interrupt.
module la_counter_ctrl #(
    parameter int unsigned BITS  = 32,
    parameter int unsigned CHK_W = 16
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             wbs_cyc_i,
    input  logic             wbs_stb_i,
    input  logic             wbs_we_i,
    input  logic [3:0]       wbs_sel_i,
    input  logic [31:0]      wbs_adr_i,
    input  logic [31:0]      wbs_dat_i,
    output logic             wbs_ack_o,
    output logic [31:0]      wbs_dat_o,
    input  logic             la_load_i,
    input  logic [BITS-1:0]  la_load_val_i,
    output logic [BITS-1:0]  count_o,
    output logic [CHK_W-1:0] chk_o,
    output logic             irq_o
);

    localparam int unsigned CTRL_W  = 16;
    localparam int unsigned PRESC_W = 8;
    localparam logic [1:0]  ADR_CTRL   = 2'd0;
    localparam logic [1:0]  ADR_LOAD   = 2'd1;
    localparam logic [1:0]  ADR_LIMIT  = 2'd2;
    localparam logic [1:0]  ADR_STATUS = 2'd3;
    localparam logic [7:0]  BEACON_TAG = 8'hAB;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [CTRL_W-1:0]  ctrl_q, ctrl_d;
    logic [BITS-1:0]    load_q, load_d;
    logic [BITS-1:0]    limit_q, limit_d;
    logic [BITS-1:0]    count_q, count_d;
    logic [PRESC_W-1:0] presc_cnt_q, presc_cnt_d;
    logic               done_q, done_d;
    logic               irq_q, irq_d;
    logic               ack_q, ack_d;
    logic [31:0]        dat_q, dat_d;
    logic [CHK_W-1:0]   chk_q, chk_d;

    // Per-byte write merge shared by all writable registers.
    function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  sel);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) begin
            r[b*8 +: 8] = sel[b] ? new_v[b*8 +: 8] : old_v[b*8 +: 8];
        end
        return r;
    endfunction

    logic [1:0]  adr;
    logic        acc, wr, rd;
    logic        wr_ctrl, wr_load, wr_limit, wr_status;
    logic [31:0] ctrl_m, load_m, limit_m;
    logic        en, oneshot, busy;
    logic [PRESC_W-1:0] presc;
    logic        any_load, tick, at_limit, term;
    logic [31:0] rd_data;

    // Bus decode: a new access is accepted only when the previous ack is not being driven.
    assign adr       = wbs_adr_i[3:2];
    assign acc       = wbs_cyc_i & wbs_stb_i & ~ack_q;
    assign wr        = acc & wbs_we_i;
    assign rd        = acc & ~wbs_we_i;
    assign wr_ctrl   = wr & (adr == ADR_CTRL);
    assign wr_load   = wr & (adr == ADR_LOAD);
    assign wr_limit  = wr & (adr == ADR_LIMIT);
    assign wr_status = wr & (adr == ADR_STATUS);

    assign ctrl_m  = byte_merge(32'(ctrl_q), wbs_dat_i, wbs_sel_i);
    assign load_m  = byte_merge(32'(load_q), wbs_dat_i, wbs_sel_i);
    assign limit_m = byte_merge(32'(limit_q), wbs_dat_i, wbs_sel_i);

    assign en       = ctrl_q[0];
    assign oneshot  = ctrl_q[1];
    assign presc    = ctrl_q[15:8];
    assign busy     = (state_q == ST_RUN);
    assign any_load = la_load_i | wr_load;

    // A load in the same cycle swallows the tick, so it can never produce a terminal event.
    assign tick     = busy & ~any_load & (presc_cnt_q >= presc);
    assign at_limit = (count_q == limit_q);
    assign term     = tick & at_limit;

    assign rd_data = (adr == ADR_CTRL)  ? 32'(ctrl_q)  :
                     (adr == ADR_LOAD)  ? 32'(load_q)  :
                     (adr == ADR_LIMIT) ? 32'(limit_q) :
                     {29'd0, la_load_i, done_q, busy};

    wire unused_ok = &{1'b0, wbs_adr_i[31:4], wbs_adr_i[1:0], ctrl_m[31:16]};

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (en) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (!en)                 state_d = ST_IDLE;
                else if (term && oneshot) state_d = ST_DONE;
            end
            ST_DONE: begin
                if (!en)           state_d = ST_IDLE;
                else if (any_load) state_d = ST_RUN;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ctrl_d      = ctrl_q;
        load_d      = load_q;
        limit_d     = limit_q;
        count_d     = count_q;
        presc_cnt_d = presc_cnt_q;
        done_d      = done_q;
        irq_d       = 1'b0;
        ack_d       = acc;
        dat_d       = 32'd0;

        if (wr_ctrl)  ctrl_d  = ctrl_m[CTRL_W-1:0];
        if (wr_load)  load_d  = BITS'(load_m);
        if (wr_limit) limit_d = BITS'(limit_m);
        if (rd)       dat_d   = rd_data;

        // Count source priority: LA load, then bus LOAD write, then prescaled tick.
        if (la_load_i) begin
            count_d = la_load_val_i;
        end else if (wr_load) begin
            count_d = BITS'(load_m);
        end else if (tick) begin
            if (at_limit) count_d = oneshot ? count_q : '0;
            else          count_d = count_q + BITS'(1);
        end

        irq_d = term;

        // Set beats a same-cycle write-one-to-clear.
        if (wr_status && wbs_sel_i[0] && wbs_dat_i[1]) done_d = 1'b0;
        if (term && oneshot)                          done_d = 1'b1;

        if (any_load || (!busy && state_d == ST_RUN)) begin
            presc_cnt_d = '0;
        end else if (busy) begin
            presc_cnt_d = tick ? '0 : presc_cnt_q + PRESC_W'(1);
        end

        chk_d = CHK_W'({(ctrl_d[0] ? BEACON_TAG : 8'h00), 4'(state_d), count_d[3:0]});
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            ctrl_q      <= '0;
            load_q      <= '0;
            limit_q     <= '1;
            count_q     <= '0;
            presc_cnt_q <= '0;
            done_q      <= 1'b0;
            irq_q       <= 1'b0;
            ack_q       <= 1'b0;
            dat_q       <= '0;
            chk_q       <= '0;
        end else begin
            ctrl_q      <= ctrl_d;
            load_q      <= load_d;
            limit_q     <= limit_d;
            count_q     <= count_d;
            presc_cnt_q <= presc_cnt_d;
            done_q      <= done_d;
            irq_q       <= irq_d;
            ack_q       <= ack_d;
            dat_q       <= dat_d;
            chk_q       <= chk_d;
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;
    assign count_o   = count_q;
    assign chk_o     = chk_q;
    assign irq_o     = irq_q;

endmodule
